mem_write_checker: RTL and testbench
====================================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter WIDTH, default 32, is the data and address bus width.
REQ-002 Parameter DEPTH, default 1, is the number of expected writes; allowed range 1..16.
REQ-003 Parameter IGNORE_ADR, default 96, is the address whose writes are silently skipped.
REQ-004 Parameter TIMEOUT, default 1024, is the maximum number of RUN cycles; allowed range 2..2^20.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 MemWrite  in  1  processor store strobe.
REQ-008 DataAdr  in  WIDTH  store address.
REQ-009 WriteData  in  WIDTH  store data.
REQ-010 ld_en  in  1  writes one expected-table entry.
REQ-011 ld_idx  in  clog2(DEPTH) (minimum 1)  table entry index.
REQ-012 ld_adr  in  WIDTH  expected address.
REQ-013 ld_data  in  WIDTH  expected data.
REQ-014 start  in  1  single-cycle pulse that arms the check.
REQ-015 busy  out  1  high in RUN.
REQ-016 pass  out  1  high in PASS.
REQ-017 fail  out  1  high in FAIL.
REQ-018 timeout  out  1  high in TOUT.
REQ-019 match_cnt  out  clog2(DEPTH+1)  number of expected writes matched so far.
REQ-020 fail_adr, fail_data  out  WIDTH each  the offending store, captured on entry to FAIL.

Function
REQ-021 The block SHALL implement the states IDLE, RUN, PASS, FAIL and TOUT, with all outputs registered.
REQ-022 ld_en SHALL write table[ld_idx] only in IDLE, PASS, FAIL or TOUT.
- ld_en SHALL be ignored in RUN.
- Writes with ld_idx >= DEPTH SHALL be ignored.
REQ-023 start SHALL move the block from any state except RUN into RUN on the next edge.
- On that transition, match_cnt and the cycle counter SHALL clear to 0.
- fail_adr and fail_data SHALL clear to 0.
- start received in RUN SHALL be ignored.
REQ-024 In RUN, each edge with MemWrite=1 SHALL be evaluated in this priority order:
- If DataAdr == IGNORE_ADR, the store is ignored.
- Else if DataAdr/WriteData equal table[match_cnt], match_cnt increments.
- Otherwise the block enters FAIL and captures DataAdr/WriteData.
REQ-025 A match that brings match_cnt to DEPTH SHALL move the block to PASS on the same edge.
REQ-026 The cycle counter SHALL increment on every RUN edge.
- The counter reaching TIMEOUT without PASS or FAIL SHALL move the block to TOUT.
- Timeout is therefore asserted exactly TIMEOUT edges after the start edge.
REQ-027 If a completing match and timeout occur on the same edge, PASS SHALL win.
- A mismatch on that edge SHALL produce FAIL.
REQ-028 Latency: a store sampled at edge N SHALL be reflected in outputs immediately after edge N, with no combinational path from inputs to outputs.
REQ-029 PASS, FAIL and TOUT SHALL be sticky until start or reset.
- Stores arriving in these states SHALL be ignored, and match_cnt SHALL hold.
REQ-030 In IDLE, MemWrite SHALL be ignored.
REQ-031 Comparison SHALL be full-width and exact.
- Any X or Z bit on DataAdr or WriteData during an evaluated store SHALL count as a mismatch.

Reset
REQ-032 reset=1 SHALL immediately force the following, independent of clk:
- State IDLE.
- busy, pass, fail and timeout = 0.
- match_cnt, fail_adr and fail_data = 0.
- All table entries = 0.
- Cycle counter = 0.
REQ-033 Reset asserted mid-RUN SHALL abandon the check; a new start is required after table reload.
REQ-034 The first edge after reset deassertion SHALL see the IDLE state.

Verification
REQ-035 Defaults; load (100,7); start; stores (96,5) then (100,7) -> after the second store edge: pass=1, match_cnt=1, busy=0.
REQ-036 Defaults; load (100,7); start; store (104,7) -> fail=1, fail_adr=104, fail_data=7, match_cnt=0; a later (100,7) store leaves pass=0.
REQ-037 DEPTH=4; table (0,1),(4,2),(8,3),(12,4); in-order stores -> pass=1 after the fourth store. Rerun with stores (0,1),(8,3) -> fail=1, fail_adr=8, match_cnt=1.
REQ-038 TIMEOUT=16; start with no stores -> busy for 16 cycles, then timeout=1. In a separate run, the matching final store lands on the 16th edge -> pass=1, timeout=0.
REQ-039 DEPTH=2; one match, then reset pulsed between edges -> all outputs 0 at once, table reads 0. ld_en pulsed during RUN with a different entry -> the original table still governs the result.

Source files
------------

// File: rtl/mem_write_checker.sv
// mem_write_checker: watches a processor store port and checks that the
// stores arrive in the order and with the values held in a small expected
// table. Stores to IGNORE_ADR are skipped. The check ends in PASS, FAIL or
// TOUT and stays there until the next start or reset.
module mem_write_checker #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1,
  parameter int IGNORE_ADR = 96,
  parameter int TIMEOUT    = 1024,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [WIDTH-1:0] ld_adr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [WIDTH-1:0] fail_adr,
  output logic [WIDTH-1:0] fail_data
);

  // The cycle counter only needs to reach TIMEOUT-1; the RUN edge that
  // would make it TIMEOUT is the edge that moves to TOUT.
  localparam int CYC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [WIDTH-1:0] IGN_ADR  = WIDTH'(IGNORE_ADR);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CYC_W-1:0]   cyc, cyc_n;
  logic [CNT_W-1:0]   mcnt_n;
  logic               cap, clr;

  logic [WIDTH-1:0]   tbl_adr  [DEPTH];
  logic [WIDTH-1:0]   tbl_data [DEPTH];
  logic [WIDTH-1:0]   exp_adr, exp_data;
  logic               is_ign, is_match;

  // Select the table entry that the next evaluated store must match.
  always_comb begin
    exp_adr  = '0;
    exp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_cnt == CNT_W'(i)) begin
        exp_adr  = tbl_adr[i];
        exp_data = tbl_data[i];
      end
    end
  end

  // Unknown bits make these compares non-true, so the store falls through
  // to the mismatch branch below.
  always_comb begin
    is_ign   = (DataAdr == IGN_ADR);
    is_match = (DataAdr == exp_adr) && (WriteData == exp_data);
  end

  // Next-state and counter logic; PASS or FAIL on the final edge beats TOUT.
  always_comb begin
    state_n = state;
    mcnt_n  = match_cnt;
    cyc_n   = cyc;
    cap     = 1'b0;
    clr     = 1'b0;
    case (state)
      RUN: begin
        cyc_n = cyc + CYC_W'(1);
        if (MemWrite) begin
          if (is_ign) begin
            state_n = RUN;
          end else if (is_match) begin
            mcnt_n = match_cnt + CNT_W'(1);
            if (mcnt_n == CNT_DONE) state_n = PASS;
          end else begin
            state_n = FAIL;
            cap     = 1'b1;
          end
        end
        if ((state_n == RUN) && (cyc == CYC_LAST)) state_n = TOUT;
      end
      default: begin
        if (start) begin
          state_n = RUN;
          mcnt_n  = '0;
          cyc_n   = '0;
          clr     = 1'b1;
        end
      end
    endcase
  end

  // State register with registered status outputs decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      match_cnt <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      match_cnt <= mcnt_n;
      busy      <= (state_n == RUN);
      pass      <= (state_n == PASS);
      fail      <= (state_n == FAIL);
      timeout   <= (state_n == TOUT);
    end
  end

  // Capture the offending store on entry to FAIL; clear on a new start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (clr) begin
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (cap) begin
      fail_adr  <= DataAdr;
      fail_data <= WriteData;
    end
  end

  // Expected table: writable outside RUN only; indices past DEPTH match
  // no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_adr[i]  <= '0;
        tbl_data[i] <= '0;
      end
    end else if (ld_en && (state != RUN)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_idx == IDX_W'(i)) begin
          tbl_adr[i]  <= ld_adr;
          tbl_data[i] <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three instances (default, DEPTH=4,
// DEPTH=2/TIMEOUT=16) share the store and load buses, each with its own start.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mw;
  logic [31:0] adr, wdata;
  logic        ld_en;
  logic [1:0]  ld_idx;
  logic [31:0] ld_adr, ld_data;
  logic        start_a, start_b, start_c;

  logic        busy_a, pass_a, fail_a, tout_a;
  logic [0:0]  mc_a;
  logic [31:0] fadr_a, fdat_a;
  logic        busy_b, pass_b, fail_b, tout_b;
  logic [2:0]  mc_b;
  logic [31:0] fadr_b, fdat_b;
  logic        busy_c, pass_c, fail_c, tout_c;
  logic [1:0]  mc_c;
  logic [31:0] fadr_c, fdat_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_write_checker dut_a (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(wdata),
    .ld_en(ld_en), .ld_idx(ld_idx[0:0]), .ld_adr(ld_adr), .ld_data(ld_data),
    .start(start_a), .busy(busy_a), .pass(pass_a), .fail(fail_a),
    .timeout(tout_a), .match_cnt(mc_a), .fail_adr(fadr_a), .fail_data(fdat_a)
  );

  mem_write_checker #(.DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(wdata),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_adr(ld_adr), .ld_data(ld_data),
    .start(start_b), .busy(busy_b), .pass(pass_b), .fail(fail_b),
    .timeout(tout_b), .match_cnt(mc_b), .fail_adr(fadr_b), .fail_data(fdat_b)
  );

  mem_write_checker #(.DEPTH(2), .TIMEOUT(16)) dut_c (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(wdata),
    .ld_en(ld_en), .ld_idx(ld_idx[0:0]), .ld_adr(ld_adr), .ld_data(ld_data),
    .start(start_c), .busy(busy_c), .pass(pass_c), .fail(fail_c),
    .timeout(tout_c), .match_cnt(mc_c), .fail_adr(fadr_c), .fail_data(fdat_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = idx; ld_adr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mw = 1'b1; adr = a; wdata = d;
    tick();
    mw = 1'b0;
  endtask

  task automatic go(input int k);
    start_a = (k == 0); start_b = (k == 1); start_c = (k == 2);
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mw = 1'b0; adr = '0; wdata = '0;
    ld_en = 1'b0; ld_idx = '0; ld_adr = '0; ld_data = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tick(); tick();

    // Reset state of every output on every instance
    chk("rst busy_a", 64'(busy_a), 64'd0);
    chk("rst pass_a", 64'(pass_a), 64'd0);
    chk("rst fail_a", 64'(fail_a), 64'd0);
    chk("rst tout_a", 64'(tout_a), 64'd0);
    chk("rst mc_a",   64'(mc_a),   64'd0);
    chk("rst fadr_a", 64'(fadr_a), 64'd0);
    chk("rst fdat_a", 64'(fdat_a), 64'd0);
    chk("rst busy_b", 64'(busy_b), 64'd0);
    chk("rst pass_b", 64'(pass_b), 64'd0);
    chk("rst fail_b", 64'(fail_b), 64'd0);
    chk("rst tout_b", 64'(tout_b), 64'd0);
    chk("rst mc_b",   64'(mc_b),   64'd0);
    chk("rst fadr_b", 64'(fadr_b), 64'd0);
    chk("rst fdat_b", 64'(fdat_b), 64'd0);
    chk("rst busy_c", 64'(busy_c), 64'd0);
    chk("rst tout_c", 64'(tout_c), 64'd0);
    chk("rst mc_c",   64'(mc_c),   64'd0);
    reset = 1'b0;
    tick();

    // Store in IDLE is ignored
    store(32'd20, 32'd1);
    chk("idle busy_c", 64'(busy_c), 64'd0);
    chk("idle mc_c",   64'(mc_c),   64'd0);

    // Default instance: ignored address, then match; idx 1 >= DEPTH dropped
    load(2'd0, 32'd100, 32'd7);
    load(2'd1, 32'd200, 32'd9);
    go(0);
    chk("a busy after start", 64'(busy_a), 64'd1);
    store(32'd96, 32'd5);
    chk("a ign busy", 64'(busy_a), 64'd1);
    chk("a ign mc",   64'(mc_a),   64'd0);
    store(32'd100, 32'd7);
    chk("a pass",      64'(pass_a), 64'd1);
    chk("a pass mc",   64'(mc_a),   64'd1);
    chk("a pass busy", 64'(busy_a), 64'd0);

    // Default instance: mismatch, then a late good store stays failed
    go(0);
    chk("a restart pass", 64'(pass_a), 64'd0);
    chk("a restart mc",   64'(mc_a),   64'd0);
    store(32'd104, 32'd7);
    chk("a fail",      64'(fail_a), 64'd1);
    chk("a fail adr",  64'(fadr_a), 64'd104);
    chk("a fail data", 64'(fdat_a), 64'd7);
    chk("a fail mc",   64'(mc_a),   64'd0);
    store(32'd100, 32'd7);
    chk("a sticky pass", 64'(pass_a), 64'd0);
    chk("a sticky fail", 64'(fail_a), 64'd1);

    // DEPTH=4: in-order sequence
    load(2'd0, 32'd0,  32'd1);
    load(2'd1, 32'd4,  32'd2);
    load(2'd2, 32'd8,  32'd3);
    load(2'd3, 32'd12, 32'd4);
    go(1);
    for (int k = 0; k < 4; k++) begin
      store(32'(4 * k), 32'(k + 1));
      chk("b seq mc",   64'(mc_b),   64'(k + 1));
      chk("b seq pass", 64'(pass_b), (k == 3) ? 64'd1 : 64'd0);
    end

    // DEPTH=4: skip an entry
    go(1);
    chk("b rerun mc", 64'(mc_b), 64'd0);
    store(32'd0, 32'd1);
    chk("b rerun mc1", 64'(mc_b), 64'd1);
    store(32'd8, 32'd3);
    chk("b skip fail", 64'(fail_b), 64'd1);
    chk("b skip adr",  64'(fadr_b), 64'd8);
    chk("b skip data", 64'(fdat_b), 64'd3);
    chk("b skip mc",   64'(mc_b),   64'd1);
    go(1);
    chk("b start clears adr",  64'(fadr_b), 64'd0);
    chk("b start clears data", 64'(fdat_b), 64'd0);

    // DEPTH=2, TIMEOUT=16: no stores -> 16 busy cycles then timeout
    load(2'd0, 32'd20, 32'd1);
    load(2'd1, 32'd24, 32'd2);
    go(2);
    chk("c busy e0", 64'(busy_c), 64'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("c busy run", 64'(busy_c), 64'd1);
      chk("c no tout",  64'(tout_c), 64'd0);
    end
    tick();
    chk("c tout",      64'(tout_c), 64'd1);
    chk("c tout busy", 64'(busy_c), 64'd0);

    // Final match on the 16th edge: PASS beats timeout
    go(2);
    repeat (14) tick();
    store(32'd20, 32'd1);
    chk("c late mc", 64'(mc_c), 64'd1);
    store(32'd24, 32'd2);
    chk("c edge pass", 64'(pass_c), 64'd1);
    chk("c edge tout", 64'(tout_c), 64'd0);

    // Load during RUN is ignored
    go(2);
    store(32'd20, 32'd1);
    load(2'd1, 32'd77, 32'd77);
    chk("c ld run busy", 64'(busy_c), 64'd1);
    store(32'd24, 32'd2);
    chk("c ld run pass", 64'(pass_c), 64'd1);

    // Reset pulsed between edges mid-RUN
    go(2);
    store(32'd20, 32'd1);
    chk("c pre-rst mc", 64'(mc_c), 64'd1);
    reset = 1'b1;
    #2;
    chk("c arst busy", 64'(busy_c), 64'd0);
    chk("c arst mc",   64'(mc_c),   64'd0);
    chk("c arst pass", 64'(pass_c), 64'd0);
    chk("c arst tout", 64'(tout_c), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("c post-rst idle", 64'(busy_c), 64'd0);
    go(2);
    store(32'd0, 32'd0);
    chk("c zero table mc", 64'(mc_c), 64'd1);
    store(32'd0, 32'd0);
    chk("c zero table pass", 64'(pass_c), 64'd1);

    // Mismatch capture on DEPTH=2 instance
    go(2);
    store(32'd96, 32'd1);
    store(32'd5, 32'd6);
    chk("c fail",      64'(fail_c), 64'd1);
    chk("c fail adr",  64'(fadr_c), 64'd5);
    chk("c fail data", 64'(fdat_c), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
